// File: rtl/ext_arb_pkg.sv
// ext_arb_pkg: shared state encoding, channel indices and counter width for the external-memory arbiter
package ext_arb_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  localparam int ROM_CH = 0;
  localparam int RAM_CH = 1;
  localparam int CNT_W = 4;
endpackage

// File: rtl/ext_arb_picker.sv
// ext_arb_picker: one-hot winner selection, fixed priority or round-robin when EXT_ARB_RR_EN is defined
module ext_arb_picker #(
  parameter int NUM_SRC = 2,
  parameter int PTR_W = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
`ifdef EXT_ARB_RR_EN
  input  logic [PTR_W-1:0]   ptr,
`endif
  output logic [NUM_SRC-1:0] winner
);
`ifdef EXT_ARB_RR_EN
  logic [NUM_SRC-1:0] hi;
  assign hi = req & ~((NUM_SRC'(1) << ptr) - NUM_SRC'(1));
  assign winner = |hi ? hi & (~hi + NUM_SRC'(1)) : req & (~req + NUM_SRC'(1));
`else
  assign winner = req & (~req + NUM_SRC'(1));
`endif
endmodule

// File: rtl/ext_mem_arbiter.sv
// ext_mem_arbiter: multi-source external-memory read arbiter with fixed read latency; EXT_ARB_RR_EN selects round-robin
module ext_mem_arbiter
  import ext_arb_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int SRC_W = 16,
  parameter int DATA_W = 17,
  parameter int READ_LAT = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_SRC-1:0]       req,
  input  logic [NUM_SRC*SRC_W-1:0] src_data,
  output logic [NUM_SRC-1:0]       grant,
  output logic                     busy,
  output logic [NUM_SRC-1:0]       ack,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data
);
  localparam int PTR_W = $clog2(NUM_SRC);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [NUM_SRC-1:0] winner;
  logic [SRC_W-1:0] sel;
  logic take;
  assign take = (state == IDLE) && |req;
`ifdef EXT_ARB_RR_EN
  logic [PTR_W-1:0] ptr, ptr_n;
  ext_arb_picker #(.NUM_SRC(NUM_SRC), .PTR_W(PTR_W)) u_picker (.req(req), .ptr(ptr), .winner(winner));
  // next search start is one past the winner, wrapping to channel 0
  always_comb begin
    ptr_n = ptr;
    for (int i = 0; i < NUM_SRC; i++)
      if (winner[i]) ptr_n = (i == NUM_SRC - 1) ? '0 : PTR_W'(i + 1);
  end
  // advance the round-robin pointer on every grant
  always_ff @(posedge clock)
    if (reset) ptr <= '0;
    else if (take) ptr <= ptr_n;
`else
  ext_arb_picker #(.NUM_SRC(NUM_SRC), .PTR_W(PTR_W)) u_picker (.req(req), .winner(winner));
`endif
  // state register
  always_ff @(posedge clock)
    state <= reset ? IDLE : state_n;
  // next state: grant in IDLE, count down the latency, pulse once in DONE
  always_comb
    state_n = (state == IDLE) ? (|req ? WAIT : IDLE) :
              (state == WAIT) ? (cnt == '0 ? DONE : WAIT) : IDLE;
  // outputs decoded from state; ack mirrors the held grant in DONE
  always_comb begin
    busy = state != IDLE;
    out_valid = state == DONE;
    ack = (state == DONE) ? grant : '0;
  end
  // one-hot mux of the granted source's word
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SRC; i++)
      sel = sel | (grant[i] ? src_data[i*SRC_W +: SRC_W] : '0);
  end
  // grant, wait counter and zero-extended capture register
  always_ff @(posedge clock)
    if (reset) begin
      grant <= '0;
      cnt <= '0;
      out_data <= '0;
    end else if (take) begin
      grant <= winner;
      cnt <= CNT_W'(READ_LAT - 1);
    end else if (state == WAIT) begin
      if (cnt == '0) out_data <= DATA_W'(sel);
      else cnt <= cnt - 1'b1;
    end else if (state == DONE) begin
      grant <= '0;
    end
endmodule

// File: tb/tb_ext_mem_arbiter.sv
// tb_ext_mem_arbiter: directed checks of the arbiter in 2-source/latency-2 and 4-source/latency-1 builds
module tb_ext_mem_arbiter;
  logic clock = 0;
  logic reset = 1;
  logic [1:0] req = '0;
  logic [31:0] src_data = '0;
  logic [1:0] grant, ack;
  logic busy, out_valid;
  logic [16:0] out_data;
  logic [3:0] req4 = '0;
  logic [31:0] src4 = '0;
  logic [3:0] grant4, ack4;
  logic busy4, out_valid4;
  logic [16:0] out_data4;
  int n_cmp = 0;
  int n_fail = 0;

  ext_mem_arbiter #(.NUM_SRC(2), .SRC_W(16), .DATA_W(17), .READ_LAT(2)) dut (
    .clock(clock), .reset(reset), .req(req), .src_data(src_data), .grant(grant),
    .busy(busy), .ack(ack), .out_valid(out_valid), .out_data(out_data));

  ext_mem_arbiter #(.NUM_SRC(4), .SRC_W(8), .DATA_W(17), .READ_LAT(1)) dut4 (
    .clock(clock), .reset(reset), .req(req4), .src_data(src4), .grant(grant4),
    .busy(busy4), .ack(ack4), .out_valid(out_valid4), .out_data(out_data4));

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1;
    step();
    step();
    reset = 0;
    for (int c = 0; c < 10; c++) begin
      n_cmp++;
      if ({grant, ack, busy, out_valid, out_data} !== 23'd0) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d got grant=%b ack=%b busy=%b valid=%b data=%h want all 0", c, grant, ack, busy, out_valid, out_data);
      end
      step();
    end
  endtask

  task automatic test_ram_read();
    src_data = {16'hBEEF, 16'h1234};
    req = 2'b10;
    step();
    n_cmp++;
    if ({grant, busy, out_valid} !== {2'b10, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL ram_c1 got grant=%b busy=%b valid=%b want 10 1 0", grant, busy, out_valid);
    end
    step();
    n_cmp++;
    if ({grant, ack, out_valid} !== {2'b10, 2'b00, 1'b0}) begin
      n_fail++;
      $display("FAIL ram_c2 got grant=%b ack=%b valid=%b want 10 00 0", grant, ack, out_valid);
    end
    step();
    n_cmp++;
    if ({grant, ack, out_valid, out_data} !== {2'b10, 2'b10, 1'b1, 17'h0BEEF}) begin
      n_fail++;
      $display("FAIL ram_c3 got grant=%b ack=%b valid=%b data=%h want 10 10 1 0beef", grant, ack, out_valid, out_data);
    end
    req = 2'b00;
    step();
    n_cmp++;
    if ({grant, ack, busy, out_valid, out_data} !== {2'b00, 2'b00, 1'b0, 1'b0, 17'h0BEEF}) begin
      n_fail++;
      $display("FAIL ram_c4 got grant=%b ack=%b busy=%b valid=%b data=%h want 00 00 0 0 0beef", grant, ack, busy, out_valid, out_data);
    end
  endtask

  task automatic test_fixed_priority();
    src_data = {16'h2222, 16'h1111};
    req = 2'b11;
    step();
    n_cmp++;
    if (grant !== 2'b01) begin
      n_fail++;
      $display("FAIL prio_first_grant got %b want 01", grant);
    end
    step();
    step();
    n_cmp++;
    if ({ack, out_valid, out_data} !== {2'b01, 1'b1, 17'h01111}) begin
      n_fail++;
      $display("FAIL prio_first_ack got ack=%b valid=%b data=%h want 01 1 01111", ack, out_valid, out_data);
    end
    req = 2'b10;
    step();
    n_cmp++;
    if ({busy, out_valid, ack} !== {1'b0, 1'b0, 2'b00}) begin
      n_fail++;
      $display("FAIL prio_idle_gap got busy=%b valid=%b ack=%b want 0 0 00", busy, out_valid, ack);
    end
    step();
    n_cmp++;
    if (grant !== 2'b10) begin
      n_fail++;
      $display("FAIL prio_second_grant got %b want 10", grant);
    end
    step();
    step();
    n_cmp++;
    if ({ack, out_valid, out_data} !== {2'b10, 1'b1, 17'h02222}) begin
      n_fail++;
      $display("FAIL prio_second_ack got ack=%b valid=%b data=%h want 10 1 02222", ack, out_valid, out_data);
    end
    req = 2'b00;
    step();
  endtask

  task automatic test_alternate();
    logic [1:0] want;
    src_data = {16'hAAAA, 16'h5555};
    for (int k = 0; k < 4; k++) begin
`ifdef EXT_ARB_RR_EN
      want = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
      want = 2'b01;
`endif
      req = 2'b11;
      step();
      n_cmp++;
      if (grant !== want) begin
        n_fail++;
        $display("FAIL alt_grant txn %0d got %b want %b", k, grant, want);
      end
      req = 2'b00;
      step();
      step();
      n_cmp++;
      if ({ack, out_valid} !== {want, 1'b1}) begin
        n_fail++;
        $display("FAIL alt_ack txn %0d got ack=%b valid=%b want %b 1", k, ack, out_valid, want);
      end
      step();
    end
  endtask

  task automatic test_drop_in_wait();
    src_data = {16'h0000, 16'hCAFE};
    req = 2'b01;
    step();
    req = 2'b00;
    step();
    n_cmp++;
    if ({grant, busy, out_valid} !== {2'b01, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL drop_wait got grant=%b busy=%b valid=%b want 01 1 0", grant, busy, out_valid);
    end
    step();
    n_cmp++;
    if ({ack, out_valid, out_data} !== {2'b01, 1'b1, 17'h0CAFE}) begin
      n_fail++;
      $display("FAIL drop_ack got ack=%b valid=%b data=%h want 01 1 0cafe", ack, out_valid, out_data);
    end
    step();
  endtask

  task automatic test_reset_in_wait();
    src_data = {16'h5A5A, 16'h0F0F};
    req = 2'b10;
    step();
    reset = 1;
    req = 2'b00;
    step();
    reset = 0;
    n_cmp++;
    if ({grant, ack, busy, out_valid, out_data} !== 23'd0) begin
      n_fail++;
      $display("FAIL rst_wait got grant=%b ack=%b busy=%b valid=%b data=%h want all 0", grant, ack, busy, out_valid, out_data);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++;
      if ({ack, busy, out_valid} !== 4'd0) begin
        n_fail++;
        $display("FAIL rst_no_ack cycle %0d got ack=%b busy=%b valid=%b want 00 0 0", c, ack, busy, out_valid);
      end
    end
    req = 2'b01;
    step();
    req = 2'b00;
    n_cmp++;
    if (grant !== 2'b01) begin
      n_fail++;
      $display("FAIL rst_new_grant got %b want 01", grant);
    end
    step();
    step();
    n_cmp++;
    if ({ack, out_valid, out_data} !== {2'b01, 1'b1, 17'h00F0F}) begin
      n_fail++;
      $display("FAIL rst_new_ack got ack=%b valid=%b data=%h want 01 1 00f0f", ack, out_valid, out_data);
    end
    step();
  endtask

  task automatic test_wide();
    src4 = {8'hA5, 8'h33, 8'h22, 8'h11};
    req4 = 4'b1000;
    step();
    req4 = 4'b0000;
    n_cmp++;
    if ({grant4, busy4, out_valid4} !== {4'b1000, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL wide_grant got grant=%b busy=%b valid=%b want 1000 1 0", grant4, busy4, out_valid4);
    end
    step();
    n_cmp++;
    if ({ack4, out_valid4, out_data4} !== {4'b1000, 1'b1, 17'h000A5}) begin
      n_fail++;
      $display("FAIL wide_ack got ack=%b valid=%b data=%h want 1000 1 000a5", ack4, out_valid4, out_data4);
    end
    n_cmp++;
    if (out_data4[16:8] !== 9'd0) begin
      n_fail++;
      $display("FAIL wide_upper got %h want 0", out_data4[16:8]);
    end
    step();
    n_cmp++;
    if ({grant4, ack4, busy4, out_valid4} !== 10'd0) begin
      n_fail++;
      $display("FAIL wide_idle got grant=%b ack=%b busy=%b valid=%b want all 0", grant4, ack4, busy4, out_valid4);
    end
  endtask

  initial begin
    test_reset();
    test_ram_read();
    test_fixed_priority();
    test_alternate();
    test_drop_in_wait();
    test_reset_in_wait();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
